// File: rtl/matvec_result_packer_pkg.sv
// rtl/matvec_result_packer_pkg.sv - shared FSM type and byte-width helpers for the result packer
package matvec_result_packer_pkg;

   typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} state_t;

   localparam int MASK_MAX_BITS = 1024;

   function automatic int beat_bytes(input int vector_size, input int entry_size);
      return vector_size * entry_size / 8;
   endfunction

   function automatic int out_bytes(input int out_width);
      return out_width / 8;
   endfunction

   // Low nbytes bytes set; callers size-cast the result down to their own width.
   function automatic logic [MASK_MAX_BITS-1:0] byte_mask(input int nbytes);
      logic [MASK_MAX_BITS-1:0] m;
      m = '0;
      for (int i = 0; i < MASK_MAX_BITS / 8; i++)
         if (i < nbytes) m[i*8 +: 8] = 8'hff;
      return m;
   endfunction

endpackage

// File: rtl/matvec_result_packer_byte_append_shifter.sv
// rtl/matvec_result_packer_byte_append_shifter.sv - optional word shift-out, then byte insert at the fill offset
module matvec_result_packer_byte_append_shifter
   import matvec_result_packer_pkg::*;
#(
   parameter int ACC_BYTES  = 88,
   parameter int BEAT_BYTES = 24,
   parameter int OUT_BYTES  = 64,
   parameter int FILL_W     = 7
) (
   input  logic [ACC_BYTES*8-1:0]  acc,
   input  logic [FILL_W-1:0]       fill,
   input  logic                    shift_en,
   input  logic                    append_en,
   input  logic [BEAT_BYTES*8-1:0] data,
   input  logic [FILL_W-1:0]       nb,
   output logic [ACC_BYTES*8-1:0]  acc_next,
   output logic [FILL_W-1:0]       fill_next
);

   localparam int ACC_W  = ACC_BYTES * 8;
   localparam int BEAT_W = BEAT_BYTES * 8;

   logic [ACC_W-1:0]  base;
   logic [ACC_W-1:0]  keep;
   logic [ACC_W-1:0]  ins;
   logic [FILL_W-1:0] base_fill;

   always_comb begin
      base      = shift_en ? (acc >> (OUT_BYTES * 8)) : acc;
      base_fill = shift_en ? fill - FILL_W'(OUT_BYTES) : fill;
      keep      = ACC_W'(byte_mask(int'(base_fill)));
      ins       = ACC_W'(data & BEAT_W'(byte_mask(int'(nb)))) << {base_fill, 3'b000};
      acc_next  = base;
      fill_next = base_fill;
      if (append_en) begin
         acc_next  = (base & keep) | ins;
         fill_next = base_fill + nb;
      end
   end

endmodule

// File: rtl/matvec_result_packer.sv
// rtl/matvec_result_packer.sv - packs header plus result-vector bytes into zero-padded output words
module matvec_result_packer
   import matvec_result_packer_pkg::*;
#(
   parameter int VECTOR_SIZE        = 3,
   parameter int ENTRY_SIZE         = 64,
   parameter int VALUE_SIZE_BYTES_NO = 2,
   parameter int OUT_WIDTH          = 512
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [8*VALUE_SIZE_BYTES_NO-1:0] in_value_size_data,
   input  logic [VECTOR_SIZE*ENTRY_SIZE-1:0] in_data,
   input  logic                             in_valid,
   input  logic                             in_last,
   output logic                             in_ready,
   output logic [OUT_WIDTH-1:0]             out_data,
   output logic                             out_valid,
   output logic                             out_last,
   input  logic                             out_ready,
   output logic                             size_err
);

   localparam int BEAT_BYTES = beat_bytes(VECTOR_SIZE, ENTRY_SIZE);
   localparam int OUT_BYTES  = out_bytes(OUT_WIDTH);
   localparam int HDR        = VALUE_SIZE_BYTES_NO;
   localparam int ACC_BYTES  = OUT_BYTES + BEAT_BYTES;
   localparam int ACC_W      = ACC_BYTES * 8;
   localparam int FILL_W     = $clog2(ACC_BYTES + 1);
   localparam int SIZE_W     = 8 * HDR;

   state_t            state_q, state_d;
   logic [ACC_W-1:0]  acc_q, acc_in, acc_next;
   logic [FILL_W-1:0] fill_q, fill_in, fill_next, nb;
   logic [SIZE_W-1:0] rem_q, rem_d, rem_cur, rem_after, hdr_rem;
   logic [OUT_WIDTH-1:0] word;
   logic load, accept, shift_en, append_en, emit, emit_last, err_d;

   assign hdr_rem = (in_value_size_data >= SIZE_W'(HDR)) ? in_value_size_data - SIZE_W'(HDR) : '0;

   always_comb begin
      load      = !out_valid || out_ready;
      in_ready  = 1'b0;
      state_d   = state_q;
      acc_in    = acc_q;
      fill_in   = fill_q;
      rem_cur   = rem_q;
      rem_d     = rem_q;
      shift_en  = 1'b0;
      append_en = 1'b0;
      emit      = 1'b0;
      emit_last = 1'b0;
      err_d     = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            acc_in   = ACC_W'(in_value_size_data);
            fill_in  = FILL_W'(HDR);
            rem_cur  = hdr_rem;
         end
         ACCUM: begin
            in_ready = fill_q < FILL_W'(OUT_BYTES);
            if (fill_q >= FILL_W'(OUT_BYTES) && load) begin
               emit     = 1'b1;
               shift_en = 1'b1;
            end
         end
         FLUSH: begin
            if (load) begin
               emit = 1'b1;
               if (fill_q > FILL_W'(OUT_BYTES)) shift_en = 1'b1;
               else emit_last = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (rst) in_ready = 1'b0;
      accept    = in_valid && in_ready;
      nb        = (rem_cur < SIZE_W'(BEAT_BYTES)) ? FILL_W'(rem_cur) : FILL_W'(BEAT_BYTES);
      rem_after = rem_cur - SIZE_W'(nb);
      if (accept) begin
         append_en = 1'b1;
         rem_d     = rem_after;
         if (in_last) state_d = FLUSH;
         else if (state_q == IDLE) state_d = ACCUM;
         // short value on the closing beat, or a beat arriving after the payload is complete
         err_d = in_last ? (rem_after != '0) : (rem_cur == '0);
      end
      if (emit_last) state_d = IDLE;
      word = acc_q[OUT_WIDTH-1:0];
      if (emit_last) word = word & OUT_WIDTH'(byte_mask(int'(fill_q)));
   end

   matvec_result_packer_byte_append_shifter #(
      .ACC_BYTES (ACC_BYTES),
      .BEAT_BYTES(BEAT_BYTES),
      .OUT_BYTES (OUT_BYTES),
      .FILL_W    (FILL_W)
   ) u_shifter (
      .acc      (acc_in),
      .fill     (fill_in),
      .shift_en (shift_en),
      .append_en(append_en),
      .data     (in_data),
      .nb       (nb),
      .acc_next (acc_next),
      .fill_next(fill_next)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         fill_q    <= '0;
         rem_q     <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         size_err  <= 1'b0;
      end else begin
         state_q  <= state_d;
         rem_q    <= rem_d;
         size_err <= err_d;
         if (emit_last) begin
            acc_q  <= '0;
            fill_q <= '0;
         end else if (append_en || shift_en) begin
            acc_q  <= acc_next;
            fill_q <= fill_next;
         end
         if (emit) begin
            out_data  <= word;
            out_valid <= 1'b1;
            out_last  <= emit_last;
         end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_matvec_result_packer.sv
// tb/tb_matvec_result_packer.sv - randomized bench against a byte-list reference model of the packer
module tb_matvec_result_packer;

   localparam int BEAT_B = 24;
   localparam int OUT_B  = 64;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [15:0]  in_value_size_data;
   logic [191:0] in_data;
   logic         in_valid, in_last, in_ready;
   logic [511:0] out_data;
   logic         out_valid, out_last, out_ready, size_err;

   int checks = 0;
   int errors = 0;
   int rdy_mode = 0;
   int err_seen = 0;
   int err_exp = 0;
   logic [511:0] exp_data_q[$];
   bit           exp_last_q[$];
   bit           stall_q = 1'b0;
   logic [511:0] stall_data;
   logic         stall_last;

   always #5 clk = ~clk;

   matvec_result_packer #(
      .VECTOR_SIZE(3), .ENTRY_SIZE(64), .VALUE_SIZE_BYTES_NO(2), .OUT_WIDTH(512)
   ) dut (
      .clk(clk), .rst(rst),
      .in_value_size_data(in_value_size_data), .in_data(in_data),
      .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
      .out_ready(out_ready), .size_err(size_err)
   );

   task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = !out_ready;
            2: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
         endcase
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            stall_q = 1'b0;
         end else begin
            if (stall_q) begin
               check_eq("held_valid", 512'(out_valid), 512'(1));
               check_eq("held_data", out_data, stall_data);
               check_eq("held_last", 512'(out_last), 512'(stall_last));
            end
            if (out_valid && out_ready) begin
               if (exp_data_q.size() == 0) begin
                  check_eq("spurious_word", 512'(out_valid), 512'(0));
               end else begin
                  check_eq("word_data", out_data, exp_data_q.pop_front());
                  check_eq("word_last", 512'(out_last), 512'(exp_last_q.pop_front()));
               end
            end
            if (size_err) err_seen++;
            stall_q    = out_valid && !out_ready;
            stall_data = out_data;
            stall_last = out_last;
         end
      end
   end

   task automatic drive_beat(input logic [191:0] d, input bit last);
      int n;
      repeat ($urandom_range(0, 1)) begin
         @(posedge clk);
         #1;
      end
      in_data  = d;
      in_last  = last;
      in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) check_eq("in_ready_timeout", 512'(in_ready), 512'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Model: the value is a byte list (header, then min(24, remaining) bytes per beat) cut into 64-byte words.
   task automatic send_value(input int size, input int nbeats, input bit expect_out);
      logic [7:0]   bq[$];
      logic [191:0] beats[$];
      logic [191:0] d;
      logic [511:0] w;
      logic [15:0]  s16;
      int rem, nb, len, nw, idx;
      s16 = 16'(size);
      bq.push_back(s16[7:0]);
      bq.push_back(s16[15:8]);
      rem = (size >= 2) ? size - 2 : 0;
      for (int k = 0; k < nbeats; k++) begin
         for (int i = 0; i < BEAT_B; i++) d[i*8 +: 8] = 8'($urandom);
         beats.push_back(d);
         nb = (rem < BEAT_B) ? rem : BEAT_B;
         if (k != nbeats - 1 && rem == 0) err_exp++;
         for (int i = 0; i < nb; i++) bq.push_back(d[i*8 +: 8]);
         rem -= nb;
         if (k == nbeats - 1 && rem != 0) err_exp++;
      end
      if (expect_out) begin
         len = bq.size();
         nw  = (len + OUT_B - 1) / OUT_B;
         for (int wi = 0; wi < nw; wi++) begin
            for (int i = 0; i < OUT_B; i++) begin
               idx = wi * OUT_B + i;
               w[i*8 +: 8] = (idx < len) ? bq[idx] : 8'h00;
            end
            exp_data_q.push_back(w);
            exp_last_q.push_back(wi == nw - 1);
         end
      end
      in_value_size_data = s16;
      for (int k = 0; k < nbeats; k++) drive_beat(beats[k], k == nbeats - 1);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_data_q.size() != 0 && n < 3000) begin
         @(posedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      check_eq("drain", 512'(exp_data_q.size()), 512'(0));
   endtask

   task automatic random_values(input int count);
      int size, need, nbeats;
      for (int v = 0; v < count; v++) begin
         size   = $urandom_range(3, 300);
         need   = (size - 2 + BEAT_B - 1) / BEAT_B;
         nbeats = need;
         if (need > 1 && $urandom_range(0, 4) == 0) nbeats = $urandom_range(1, need - 1);
         send_value(size, nbeats, 1'b1);
      end
   endtask

   initial begin
      logic [191:0] d;
      in_valid = 1'b0;
      in_last = 1'b0;
      in_data = '0;
      in_value_size_data = '0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset_out_valid", 512'(out_valid), 512'(0));
      check_eq("reset_out_last", 512'(out_last), 512'(0));
      check_eq("reset_out_data", out_data, 512'(0));
      check_eq("reset_size_err", 512'(size_err), 512'(0));
      check_eq("reset_in_ready", 512'(in_ready), 512'(0));
      rst = 1'b0;

      rdy_mode = 0;
      send_value(50, 2, 1'b1);
      send_value(98, 4, 1'b1);
      send_value(26, 1, 1'b1);
      send_value(74, 1, 1'b1);
      send_value(34, 2, 1'b1);
      send_value(26, 3, 1'b1);
      wait_drain();
      check_eq("size_err_directed", 512'(err_seen), 512'(err_exp));

      rdy_mode = 1;
      random_values(8);
      wait_drain();
      rdy_mode = 2;
      random_values(25);
      wait_drain();
      check_eq("size_err_random", 512'(err_seen), 512'(err_exp));

      rdy_mode = 3;
      repeat (3) @(posedge clk);
      #1;
      send_value(26, 1, 1'b0);
      in_value_size_data = 16'd98;
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < BEAT_B; i++) d[i*8 +: 8] = 8'($urandom);
         drive_beat(d, 1'b0);
      end
      check_eq("pre_reset_held_valid", 512'(out_valid), 512'(1));
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_eq("async_reset_out_valid", 512'(out_valid), 512'(0));
      check_eq("async_reset_in_ready", 512'(in_ready), 512'(0));
      check_eq("async_reset_out_data", out_data, 512'(0));
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      rdy_mode = 0;
      send_value(50, 2, 1'b1);
      send_value(98, 4, 1'b1);
      wait_drain();
      repeat (3) @(posedge clk);
      #1;
      check_eq("size_err_total", 512'(err_seen), 512'(err_exp));
      check_eq("final_idle", 512'(out_valid), 512'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
